// File: rtl/lsu_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_access_unit_if
// Description : Request/response and data-memory bundle of the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_access_unit_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    logic              io_req_valid;
    logic              io_req_ready;
    logic [ADDR_W-1:0] io_req_addr;
    logic [DATA_W-1:0] io_req_wdata;
    logic [2:0]        io_req_func3;
    logic              io_req_isStore;
    logic              io_flush;
    logic              io_resp_valid;
    logic              io_resp_ready;
    logic [DATA_W-1:0] io_resp_data;
    logic [ADDR_W-1:0] io_mem_dataAddr;
    logic              io_mem_writeEn;
    logic [DATA_W-1:0] io_mem_writeData;
    logic [2:0]        io_mem_func3;
    logic [DATA_W-1:0] io_mem_lsu_data;
    logic              io_busy;

    modport slave (
        input  io_req_valid, io_req_addr, io_req_wdata, io_req_func3, io_req_isStore,
        input  io_flush, io_resp_ready, io_mem_lsu_data,
        output io_req_ready, io_resp_valid, io_resp_data, io_mem_dataAddr,
        output io_mem_writeEn, io_mem_writeData, io_mem_func3, io_busy
    );

    modport master (
        output io_req_valid, io_req_addr, io_req_wdata, io_req_func3, io_req_isStore,
        output io_flush, io_resp_ready, io_mem_lsu_data,
        input  io_req_ready, io_resp_valid, io_resp_data, io_mem_dataAddr,
        input  io_mem_writeEn, io_mem_writeData, io_mem_func3, io_busy
    );
endinterface
`default_nettype wire

// File: rtl/lsu_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : lsu_access_unit
// Description : Word-only load/store sequencer with misalignment splitting,
//               read-merge-write stores and load extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_access_unit #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
) (
    input  wire logic        clock,
    input  wire logic        reset,
    lsu_access_unit_if.slave bus
);
    localparam int c_BYTES = DATA_W / 8;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_LD_LO    = 3'd1;
    localparam logic [2:0] c_LD_HI    = 3'd2;
    localparam logic [2:0] c_ST_RD_LO = 3'd3;
    localparam logic [2:0] c_ST_WR_LO = 3'd4;
    localparam logic [2:0] c_ST_RD_HI = 3'd5;
    localparam logic [2:0] c_ST_WR_HI = 3'd6;
    localparam logic [2:0] c_RESP     = 3'd7;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic              r_store;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_hi;

    logic                  w_accept;
    logic                  w_req_aligned_word;
    logic [3:0]            w_n;
    logic [1:0]            w_off;
    logic                  w_cross;
    logic [4:0]            w_shamt;
    logic [ADDR_W-1:0]     w_base;
    logic [ADDR_W-1:0]     w_base_hi;
    logic [2*DATA_W-1:0]   w_wdata_sh;
    logic [2*c_BYTES-1:0]  w_size_mask;
    logic [2*c_BYTES-1:0]  w_bmask;
    logic [DATA_W-1:0]     w_merge_lo;
    logic [DATA_W-1:0]     w_merge_hi;
    logic [DATA_W-1:0]     w_ld_raw;
    logic [DATA_W-1:0]     w_ld_ext;

    assign w_accept           = bus.io_req_valid && (r_state == c_IDLE) && !bus.io_flush;
    assign w_req_aligned_word = bus.io_req_func3[1] && (bus.io_req_addr[1:0] == 2'b00);

    assign w_n       = r_size[1] ? 4'd4 : (r_size[0] ? 4'd2 : 4'd1);
    assign w_off     = r_addr[1:0];
    assign w_cross   = ({2'b00, w_off} + w_n) > 4'd4;
    assign w_shamt   = {w_off, 3'b000};
    assign w_base    = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_base_hi = w_base + {{(ADDR_W-3){1'b0}}, 3'b100};

    // Store data and byte mask span two words so the high half feeds the second write.
    assign w_wdata_sh  = {{DATA_W{1'b0}}, r_wdata} << w_shamt;
    assign w_size_mask = r_size[1] ? {{c_BYTES{1'b0}}, {c_BYTES{1'b1}}}
                       : (r_size[0] ? 8'h03 : 8'h01);
    assign w_bmask     = w_size_mask << w_off;

    generate
        for (genvar i = 0; i < c_BYTES; i++) begin : g_merge
            assign w_merge_lo[8*i +: 8] = w_bmask[i]
                                        ? w_wdata_sh[8*i +: 8] : r_lo[8*i +: 8];
            assign w_merge_hi[8*i +: 8] = w_bmask[c_BYTES+i]
                                        ? w_wdata_sh[DATA_W+8*i +: 8] : r_hi[8*i +: 8];
        end
    endgenerate

    assign w_ld_raw = DATA_W'({r_hi, r_lo} >> w_shamt);

    always_comb begin
        w_ld_ext = w_ld_raw;
        case (r_size)
            2'b00:   w_ld_ext = {{(DATA_W-8){w_ld_raw[7] & ~r_unsigned}}, w_ld_raw[7:0]};
            2'b01:   w_ld_ext = {{(DATA_W-16){w_ld_raw[15] & ~r_unsigned}}, w_ld_raw[15:0]};
            default: w_ld_ext = w_ld_raw;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (!bus.io_req_isStore)     w_next = c_LD_LO;
                    else if (w_req_aligned_word) w_next = c_ST_WR_LO;
                    else                         w_next = c_ST_RD_LO;
                end
            end
            c_LD_LO:    w_next = bus.io_flush ? c_IDLE : (w_cross ? c_LD_HI : c_RESP);
            c_LD_HI:    w_next = bus.io_flush ? c_IDLE : c_RESP;
            c_ST_RD_LO: w_next = bus.io_flush ? c_IDLE : c_ST_WR_LO;
            // Once the low word is written the access must run to completion.
            c_ST_WR_LO: w_next = w_cross ? c_ST_RD_HI : c_RESP;
            c_ST_RD_HI: w_next = c_ST_WR_HI;
            c_ST_WR_HI: w_next = c_RESP;
            c_RESP:     w_next = (bus.io_flush || bus.io_resp_ready) ? c_IDLE : c_RESP;
            default:    w_next = c_IDLE;
        endcase
    end

    always_comb begin
        bus.io_req_ready     = (r_state == c_IDLE);
        bus.io_busy          = (r_state != c_IDLE);
        bus.io_resp_valid    = (r_state == c_RESP);
        bus.io_resp_data     = (r_state == c_RESP && !r_store) ? w_ld_ext : '0;
        bus.io_mem_func3     = 3'b010;
        bus.io_mem_dataAddr  = '0;
        bus.io_mem_writeEn   = 1'b0;
        bus.io_mem_writeData = '0;
        case (r_state)
            c_LD_LO, c_ST_RD_LO: bus.io_mem_dataAddr = w_base;
            c_LD_HI, c_ST_RD_HI: bus.io_mem_dataAddr = w_base_hi;
            c_ST_WR_LO: begin
                bus.io_mem_dataAddr  = w_base;
                bus.io_mem_writeEn   = !reset;
                bus.io_mem_writeData = w_merge_lo;
            end
            c_ST_WR_HI: begin
                bus.io_mem_dataAddr  = w_base_hi;
                bus.io_mem_writeEn   = !reset;
                bus.io_mem_writeData = w_merge_hi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_store    <= 1'b0;
            r_lo       <= '0;
            r_hi       <= '0;
        end else begin
            if (w_accept) begin
                r_addr     <= bus.io_req_addr;
                r_wdata    <= bus.io_req_wdata;
                r_size     <= bus.io_req_func3[1:0];
                r_unsigned <= bus.io_req_func3[2];
                r_store    <= bus.io_req_isStore;
                r_lo       <= '0;
                r_hi       <= '0;
            end
            if (r_state == c_LD_LO || r_state == c_ST_RD_LO) r_lo <= bus.io_mem_lsu_data;
            if (r_state == c_LD_HI || r_state == c_ST_RD_HI) r_hi <= bus.io_mem_lsu_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lsu_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_access_unit
// Description : Scoreboard bench for lsu_access_unit with a word memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_access_unit;
    typedef struct {
        logic [31:0] d;
        int          lat;
        int          c0;
    } exp_t;
    typedef struct packed {
        logic [63:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic pre_req = 1'b0;

    logic [31:0] mem [0:63];
    exp_t        exp_q[$];
    wr_t         wr_exp[$];
    wr_t         wr_act[$];
    logic [63:0] rd_act[$];

    lsu_access_unit_if #(.ADDR_W(64), .DATA_W(32)) bus ();

    lsu_access_unit #(.ADDR_W(64), .DATA_W(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb bus.io_mem_lsu_data = mem[bus.io_mem_dataAddr[7:2]];

    always @(posedge clk) begin
        if (pre_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h8877_6655;
            mem[1] <= 32'h4433_2211;
        end else if (bus.io_mem_writeEn) begin
            mem[bus.io_mem_dataAddr[7:2]] <= bus.io_mem_writeData;
            wr_act.push_back({bus.io_mem_dataAddr, bus.io_mem_writeData});
        end
        if (bus.io_busy && !bus.io_mem_writeEn && !bus.io_resp_valid && bus.io_mem_dataAddr != 64'h0)
            rd_act.push_back(bus.io_mem_dataAddr);
    end

    task automatic preload();
        @(negedge clk);
        pre_req = 1'b1;
        @(negedge clk);
        pre_req = 1'b0;
    endtask

    task automatic issue(input logic [63:0] a, input logic [31:0] wd, input logic [2:0] f3,
                         input logic st, input logic [31:0] exp_d, input int exp_lat);
        exp_t e;
        @(negedge clk);
        bus.io_req_valid   = 1'b1;
        bus.io_req_addr    = a;
        bus.io_req_wdata   = wd;
        bus.io_req_func3   = f3;
        bus.io_req_isStore = st;
        n_tests++;
        if (bus.io_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready addr=%h: req_ready=%b required 1", a, bus.io_req_ready);
        end
        e.d = exp_d; e.lat = exp_lat; e.c0 = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        bus.io_req_valid = 1'b0;
    endtask

    task automatic sb_resp(input string tag);
        exp_t e;
        int   k;
        e = exp_q.pop_front();
        k = 0;
        while (bus.io_resp_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (bus.io_resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s resp_timeout: resp_valid=%b required 1", tag, bus.io_resp_valid);
        end else begin
            n_tests++;
            if (bus.io_resp_data !== e.d) begin
                n_fail++;
                $display("FAIL %s resp_data: got %h required %h", tag, bus.io_resp_data, e.d);
            end
            n_tests++;
            if (cyc - e.c0 !== e.lat) begin
                n_fail++;
                $display("FAIL %s latency: got %0d required %0d", tag, cyc - e.c0, e.lat);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sb_writes(input string tag);
        n_tests++;
        if (wr_act.size() != wr_exp.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d required %0d", tag, wr_act.size(), wr_exp.size());
        end
        for (int i = 0; i < wr_exp.size() && i < wr_act.size(); i++) begin
            n_tests++;
            if (wr_act[i] !== wr_exp[i]) begin
                n_fail++;
                $display("FAIL %s write%0d: got %h<=%h required %h<=%h", tag, i,
                         wr_act[i].a, wr_act[i].d, wr_exp[i].a, wr_exp[i].d);
            end
        end
        wr_act.delete();
        wr_exp.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.io_req_valid   = 1'b1;
        bus.io_req_addr    = 64'h100;
        bus.io_req_func3   = 3'b000;
        bus.io_req_isStore = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.io_req_ready, bus.io_resp_valid, bus.io_mem_writeEn, bus.io_busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/rv/we/busy=%b required 1000",
                     {bus.io_req_ready, bus.io_resp_valid, bus.io_mem_writeEn, bus.io_busy});
        end
        n_tests++;
        if (bus.io_resp_data !== 32'h0 || bus.io_mem_writeData !== 32'h0 || bus.io_mem_dataAddr !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got resp=%h wd=%h addr=%h required zeros",
                     bus.io_resp_data, bus.io_mem_writeData, bus.io_mem_dataAddr);
        end
        n_tests++;
        if (bus.io_mem_func3 !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_func3: got %b required 010", bus.io_mem_func3);
        end
        bus.io_req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.io_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ignore_req: busy=%b required 0", bus.io_busy);
        end
    endtask

    task automatic test_load();
        preload();
        issue(64'h103, 32'h0, 3'b000, 1'b0, 32'hFFFF_FF88, 2); sb_resp("lb_103");
        issue(64'h103, 32'h0, 3'b100, 1'b0, 32'h0000_0088, 2); sb_resp("lbu_103");
        rd_act.delete();
        issue(64'h103, 32'h0, 3'b001, 1'b0, 32'h0000_1188, 3); sb_resp("lh_103");
        n_tests++;
        if (rd_act.size() != 2) begin
            n_fail++;
            $display("FAIL lh_103 read_count: got %0d required 2", rd_act.size());
        end else begin
            n_tests++;
            if (rd_act[0] !== 64'h100 || rd_act[1] !== 64'h104) begin
                n_fail++;
                $display("FAIL lh_103 read_addrs: got %h,%h required 100,104", rd_act[0], rd_act[1]);
            end
        end
        issue(64'h102, 32'h0, 3'b001, 1'b0, 32'hFFFF_8877, 2); sb_resp("lh_102");
        issue(64'h102, 32'h0, 3'b101, 1'b0, 32'h0000_8877, 2); sb_resp("lhu_102");
        issue(64'h101, 32'h0, 3'b010, 1'b0, 32'h1188_7766, 3); sb_resp("lw_101");
        sb_writes("loads");
    endtask

    task automatic test_store();
        preload();
        issue(64'h101, 32'h0000_00AB, 3'b000, 1'b1, 32'h0, 3);
        wr_exp.push_back({64'h100, 32'h8877_AB55});
        sb_resp("sb_101");
        sb_writes("sb_101");
        preload();
        issue(64'h102, 32'hDEAD_BEEF, 3'b010, 1'b1, 32'h0, 5);
        wr_exp.push_back({64'h100, 32'hBEEF_6655});
        wr_exp.push_back({64'h104, 32'h4433_DEAD});
        sb_resp("sw_102");
        sb_writes("sw_102");
        issue(64'h108, 32'h1122_3344, 3'b010, 1'b1, 32'h0, 2);
        wr_exp.push_back({64'h108, 32'h1122_3344});
        sb_resp("sw_108");
        sb_writes("sw_108");
        issue(64'h106, 32'h0000_A5C3, 3'b001, 1'b1, 32'h0, 3);
        wr_exp.push_back({64'h104, 32'hA5C3_DEAD});
        sb_resp("sh_106");
        sb_writes("sh_106");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   k;
        preload();
        bus.io_resp_ready = 1'b0;
        issue(64'h104, 32'h0, 3'b010, 1'b0, 32'h4433_2211, 2);
        e = exp_q.pop_front();
        k = 0;
        while (bus.io_resp_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (cyc - e.c0 !== e.lat) begin
            n_fail++;
            $display("FAIL hold latency: got %0d required %0d", cyc - e.c0, e.lat);
        end
        bus.io_req_valid   = 1'b1;
        bus.io_req_addr    = 64'h100;
        bus.io_req_func3   = 3'b000;
        bus.io_req_isStore = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (bus.io_resp_valid !== 1'b1 || bus.io_resp_data !== e.d || bus.io_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cycle%0d: rv=%b data=%h rdy=%b required 1 %h 0",
                         i, bus.io_resp_valid, bus.io_resp_data, bus.io_req_ready, e.d);
            end
            @(negedge clk);
        end
        bus.io_req_valid  = 1'b0;
        bus.io_resp_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.io_busy !== 1'b0 || bus.io_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold release: busy=%b rv=%b required 0 0", bus.io_busy, bus.io_resp_valid);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        int   seen;
        preload();
        @(negedge clk);
        bus.io_req_valid = 1'b1;
        bus.io_flush     = 1'b1;
        bus.io_req_addr  = 64'h100;
        bus.io_req_func3 = 3'b010;
        bus.io_req_isStore = 1'b0;
        @(negedge clk);
        bus.io_req_valid = 1'b0;
        bus.io_flush     = 1'b0;
        n_tests++;
        if (bus.io_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: busy=%b required 0", bus.io_busy);
        end
        issue(64'h100, 32'h0, 3'b000, 1'b0, 32'h0, 2);
        e = exp_q.pop_front();
        bus.io_flush = 1'b1;
        @(negedge clk);
        bus.io_flush = 1'b0;
        n_tests++;
        if (bus.io_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ld_lo busy: got %b required 0", bus.io_busy);
        end
        seen = 0;
        repeat (4) begin
            if (bus.io_resp_valid === 1'b1) seen++;
            @(negedge clk);
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL flush_ld_lo resp: got %0d resp cycles required 0", seen);
        end
        issue(64'h101, 32'hCAFE_F00D, 3'b010, 1'b1, 32'h0, 5);
        wr_exp.push_back({64'h100, 32'hFEF0_0D55});
        wr_exp.push_back({64'h104, 32'h4433_22CA});
        @(negedge clk);
        bus.io_flush = 1'b1;
        @(negedge clk);
        bus.io_flush = 1'b0;
        sb_resp("flush_st_wr_lo");
        sb_writes("flush_st_wr_lo");
    endtask

    task automatic test_reset_mid();
        exp_t e;
        preload();
        issue(64'h101, 32'h0000_005A, 3'b000, 1'b1, 32'h0, 3);
        e = exp_q.pop_front();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (bus.io_busy !== 1'b0 || bus.io_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid state: busy=%b rv=%b required 0 0", bus.io_busy, bus.io_resp_valid);
        end
        n_tests++;
        if (mem[0] !== 32'h8877_6655) begin
            n_fail++;
            $display("FAIL reset_mid mem: got %h required 88776655", mem[0]);
        end
        sb_writes("reset_mid");
    endtask

    initial begin
        rst                = 1'b1;
        bus.io_req_valid   = 1'b0;
        bus.io_req_addr    = 64'h0;
        bus.io_req_wdata   = 32'h0;
        bus.io_req_func3   = 3'b000;
        bus.io_req_isStore = 1'b0;
        bus.io_flush       = 1'b0;
        bus.io_resp_ready  = 1'b1;
        preload();
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
